// File: rtl/regfile_scoreboard_if.sv
// Bundle between the decode/writeback side of the pipeline and the LC-3
// register file + scoreboard. Master drives issue/read selects and the WB
// latch fields; slave (the register file) returns operands, CC and stall.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 16
);
  logic              issue_valid;
  logic              issue_writes;
  logic [2:0]        issue_dest;
  logic              sr1_used;
  logic              sr2_used;
  logic [2:0]        sr1_sel;
  logic [2:0]        sr2_sel;
  logic [DATA_W-1:0] sr1_out;
  logic [DATA_W-1:0] sr2_out;
  logic              stall;
  logic              wb_retire;
  logic              wb_we;
  logic [2:0]        wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              wb_setcc;
  logic [2:0]        cc_out;
  logic              sb_error;

  modport master (
    output issue_valid, issue_writes, issue_dest,
    output sr1_used, sr2_used, sr1_sel, sr2_sel,
    output wb_retire, wb_we, wb_dest, wb_data, wb_setcc,
    input  sr1_out, sr2_out, stall, cc_out, sb_error
  );

  modport slave (
    input  issue_valid, issue_writes, issue_dest,
    input  sr1_used, sr2_used, sr1_sel, sr2_sel,
    input  wb_retire, wb_we, wb_dest, wb_data, wb_setcc,
    output sr1_out, sr2_out, stall, cc_out, sb_error
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// LC-3 register file, condition codes and pending-write scoreboard.
// Registers/CC are written on the falling edge so decode sees writeback data
// in the same cycle; pending counters and the error flag update on the
// rising edge together with issue acceptance.
module regfile_scoreboard #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_scoreboard_if.slave   bus
);

  localparam logic [2:0] CC_ZERO = 3'b010;

  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];
  logic [2:0]        cc_q;
  logic [2:0]        cc_d;
  logic [1:0]        pend_q [8];
  logic [1:0]        pend_d [8];
  logic              err_q;
  logic              err_d;

  logic              hz1;
  logic              hz2;
  logic              dest_full;
  logic              stall;
  logic              accept;
  logic              issue_inc;

  // {n,z,p} from a signed writeback value; exactly one bit is ever set
  function automatic logic [2:0] cc_of(input logic signed [DATA_W-1:0] v);
    if (v < 0)       return 3'b100;
    else if (v == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  // Operand hazard; a last pending writer retiring with data this cycle clears it
  function automatic logic src_hazard(input logic used, input logic [1:0] pend,
                                      input logic retire_hit);
    return used && (pend != 2'd0) && !(retire_hit && pend == 2'd1);
  endfunction

  // Combinational read ports; the negedge write already acts as the bypass
  assign bus.sr1_out  = regs_q[bus.sr1_sel];
  assign bus.sr2_out  = regs_q[bus.sr2_sel];
  assign bus.cc_out   = cc_q;
  assign bus.sb_error = err_q;
  assign bus.stall    = stall;

  // Stall decision: RAW hazards on either source, or destination counter full
  always_comb begin
    hz1       = src_hazard(bus.sr1_used, pend_q[bus.sr1_sel],
                           bus.wb_retire && bus.wb_we && bus.wb_dest == bus.sr1_sel);
    hz2       = src_hazard(bus.sr2_used, pend_q[bus.sr2_sel],
                           bus.wb_retire && bus.wb_we && bus.wb_dest == bus.sr2_sel);
    dest_full = bus.issue_writes && pend_q[bus.issue_dest] == 2'd3 &&
                !(bus.wb_retire && bus.wb_dest == bus.issue_dest);
    stall     = bus.issue_valid && (hz1 || hz2 || dest_full);
    accept    = bus.issue_valid && !stall;
    issue_inc = accept && bus.issue_writes;
  end

  // Next register/CC contents from the writeback port
  always_comb begin
    for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
    cc_d = cc_q;
    if (bus.wb_we) begin
      regs_d[bus.wb_dest] = bus.wb_data;
      if (bus.wb_setcc) cc_d = cc_of(bus.wb_data);
    end
  end

  // Falling-edge storage of architectural registers and CC
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      cc_q <= CC_ZERO;
    end else begin
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      cc_q <= cc_d;
    end
  end

  // Pending counters: +1 on accepted write-issue, -1 on retire, floor at 0
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      pend_d[r] = pend_q[r];
      case ({issue_inc && bus.issue_dest == 3'(r), bus.wb_retire && bus.wb_dest == 3'(r)})
        2'b10:   pend_d[r] = pend_q[r] + 2'd1;
        2'b01:   if (pend_q[r] != 2'd0) pend_d[r] = pend_q[r] - 2'd1;
        default: pend_d[r] = pend_q[r];
      endcase
    end
    err_d = err_q
          | ((bus.wb_we || bus.wb_setcc) && !bus.wb_retire)
          | (bus.wb_retire && pend_q[bus.wb_dest] == 2'd0 &&
             !(issue_inc && bus.issue_dest == bus.wb_dest));
  end

  // Rising-edge scoreboard state and sticky protocol error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 8; r++) pend_q[r] <= 2'd0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) pend_q[r] <= pend_d[r];
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a behavioural model checked every
// cycle just before the rising edge, plus literal expectations per scenario.
module tb_regfile_scoreboard;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  regfile_scoreboard_if #(.DATA_W(16)) bus ();

  regfile_scoreboard #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_reg [8];
  logic [2:0]  m_cc;
  int          m_pend [8];
  bit          m_err;

  function automatic bit haz(input logic used, input logic [2:0] sel);
    bit last_writer_done;
    last_writer_done = bus.wb_retire && bus.wb_we && bus.wb_dest == sel && m_pend[sel] == 1;
    return used && m_pend[sel] > 0 && !last_writer_done;
  endfunction

  always @(negedge clk) begin
    bit exp_stall, acc;
    #4;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin m_reg[i] = 16'h0; m_pend[i] = 0; end
      m_cc  = 3'b010;
      m_err = 1'b0;
      chk("m_rst_sr1", 32'(bus.sr1_out), 32'h0);
      chk("m_rst_cc",  32'(bus.cc_out),  32'h2);
      chk("m_rst_stall", 32'(bus.stall), 32'h0);
      chk("m_rst_err", 32'(bus.sb_error), 32'h0);
    end else begin
      if (bus.wb_we) begin
        m_reg[bus.wb_dest] = bus.wb_data;
        if (bus.wb_setcc)
          m_cc = bus.wb_data[15] ? 3'b100 : (bus.wb_data == 16'h0 ? 3'b010 : 3'b001);
      end
      exp_stall = bus.issue_valid &&
                  (haz(bus.sr1_used, bus.sr1_sel) || haz(bus.sr2_used, bus.sr2_sel) ||
                   (bus.issue_writes && m_pend[bus.issue_dest] >= 3 &&
                    !(bus.wb_retire && bus.wb_dest == bus.issue_dest)));
      chk("m_sr1",   32'(bus.sr1_out),  32'(m_reg[bus.sr1_sel]));
      chk("m_sr2",   32'(bus.sr2_out),  32'(m_reg[bus.sr2_sel]));
      chk("m_cc",    32'(bus.cc_out),   32'(m_cc));
      chk("m_stall", 32'(bus.stall),    32'(exp_stall));
      chk("m_err",   32'(bus.sb_error), 32'(m_err));
      acc = bus.issue_valid && !exp_stall;
      if (bus.wb_retire && m_pend[bus.wb_dest] == 0 &&
          !(acc && bus.issue_writes && bus.issue_dest == bus.wb_dest)) m_err = 1'b1;
      if ((bus.wb_we || bus.wb_setcc) && !bus.wb_retire) m_err = 1'b1;
      if (acc && bus.issue_writes) m_pend[bus.issue_dest]++;
      if (bus.wb_retire && m_pend[bus.wb_dest] > 0) m_pend[bus.wb_dest]--;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next();
    @(posedge clk);
    #1;
    bus.issue_valid = 0; bus.issue_writes = 0; bus.issue_dest = 0;
    bus.sr1_used = 0; bus.sr2_used = 0; bus.sr1_sel = 0; bus.sr2_sel = 0;
    bus.wb_retire = 0; bus.wb_we = 0; bus.wb_dest = 0; bus.wb_data = 0; bus.wb_setcc = 0;
  endtask

  task automatic iss(input logic [2:0] d);
    bus.issue_valid = 1; bus.issue_writes = 1; bus.issue_dest = d;
  endtask

  task automatic rd1(input logic [2:0] s);
    bus.issue_valid = 1; bus.sr1_used = 1; bus.sr1_sel = s;
  endtask

  task automatic wbk(input logic r, input logic we, input logic [2:0] d,
                     input logic [15:0] data, input logic cc);
    bus.wb_retire = r; bus.wb_we = we; bus.wb_dest = d; bus.wb_data = data; bus.wb_setcc = cc;
  endtask

  initial begin
    bus.issue_valid = 0; bus.issue_writes = 0; bus.issue_dest = 0;
    bus.sr1_used = 0; bus.sr2_used = 0; bus.sr1_sel = 0; bus.sr2_sel = 0;
    bus.wb_retire = 0; bus.wb_we = 0; bus.wb_dest = 0; bus.wb_data = 0; bus.wb_setcc = 0;
    #1 reset = 1;
    next(); next(); #6;
    chk("rst_sr1", 32'(bus.sr1_out), 32'h0);
    chk("rst_sr2", 32'(bus.sr2_out), 32'h0);
    chk("rst_cc", 32'(bus.cc_out), 32'h2);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_err", 32'(bus.sb_error), 32'h0);
    next(); reset = 0;

    // R3 = 0x8001 with setcc, visible same cycle
    next(); iss(3'd3);
    next(); wbk(1, 1, 3'd3, 16'h8001, 1); bus.sr1_sel = 3'd3; #6;
    chk("r3_read", 32'(bus.sr1_out), 32'h8001);
    chk("r3_cc", 32'(bus.cc_out), 32'h4);

    // RAW on R2, same-cycle release
    next(); iss(3'd2);
    next(); rd1(3'd2); #6;
    chk("raw_stall", 32'(bus.stall), 32'h1);
    next(); rd1(3'd2); wbk(1, 1, 3'd2, 16'h0000, 1); #6;
    chk("raw_release", 32'(bus.stall), 32'h0);
    chk("raw_data", 32'(bus.sr1_out), 32'h0);
    chk("raw_cc", 32'(bus.cc_out), 32'h2);

    // Saturation on R5
    next(); iss(3'd5);
    next(); iss(3'd5);
    next(); iss(3'd5);
    next(); iss(3'd5); #6;
    chk("sat_stall", 32'(bus.stall), 32'h1);
    next(); iss(3'd5); wbk(1, 1, 3'd5, 16'h1234, 0); #6;
    chk("sat_accept", 32'(bus.stall), 32'h0);
    next(); iss(3'd5); #6;
    chk("sat_still3", 32'(bus.stall), 32'h1);
    next(); wbk(1, 1, 3'd5, 16'h0007, 1);
    next(); wbk(1, 1, 3'd5, 16'hfffe, 1);
    next(); wbk(1, 1, 3'd5, 16'h1234, 0);
    next(); rd1(3'd5); #6;
    chk("sat_drained", 32'(bus.stall), 32'h0);
    chk("sat_data", 32'(bus.sr1_out), 32'h1234);
    chk("sat_cc", 32'(bus.cc_out), 32'h4);
    chk("sat_err", 32'(bus.sb_error), 32'h0);

    // Squash of R1
    next(); iss(3'd1);
    next(); wbk(1, 0, 3'd1, 16'hffff, 1); bus.sr1_sel = 3'd1; #6;
    chk("sq_data", 32'(bus.sr1_out), 32'h0);
    chk("sq_cc", 32'(bus.cc_out), 32'h4);
    next(); rd1(3'd1); #6;
    chk("sq_nostall", 32'(bus.stall), 32'h0);

    // Simultaneous issue and retire on R4
    next(); iss(3'd4);
    next(); iss(3'd4); wbk(1, 1, 3'd4, 16'h0042, 0); #6;
    chk("sim_accept", 32'(bus.stall), 32'h0);
    next(); rd1(3'd4); #6;
    chk("sim_stall", 32'(bus.stall), 32'h1);
    chk("sim_data", 32'(bus.sr1_out), 32'h0042);
    next(); rd1(3'd4); wbk(1, 1, 3'd4, 16'h0043, 0); #6;
    chk("sim_release", 32'(bus.stall), 32'h0);
    chk("sim_data2", 32'(bus.sr1_out), 32'h0043);

    // Retire underflow on R6 -> sticky error
    next(); wbk(1, 0, 3'd6, 16'h0, 0); #6;
    chk("err_pre", 32'(bus.sb_error), 32'h0);
    next(); #6;
    chk("err_set", 32'(bus.sb_error), 32'h1);
    next(); wbk(0, 1, 3'd7, 16'h5555, 1); bus.sr2_sel = 3'd7; #6;
    chk("noret_write", 32'(bus.sr2_out), 32'h5555);
    chk("noret_cc", 32'(bus.cc_out), 32'h1);
    chk("err_sticky", 32'(bus.sb_error), 32'h1);

    // Asynchronous reset mid-cycle while a reader is stalled
    next(); iss(3'd0);
    next(); rd1(3'd0); bus.sr2_sel = 3'd7; #6;
    chk("pre_rst_stall", 32'(bus.stall), 32'h1);
    reset = 1; #1;
    chk("arst_stall", 32'(bus.stall), 32'h0);
    chk("arst_sr2", 32'(bus.sr2_out), 32'h0);
    chk("arst_cc", 32'(bus.cc_out), 32'h2);
    chk("arst_err", 32'(bus.sb_error), 32'h0);
    next(); reset = 0;
    next(); rd1(3'd0); #6;
    chk("post_rst_stall", 32'(bus.stall), 32'h0);
    next(); next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
